// File: rtl/frame_rx_pkg.sv
// Shared framing definitions for the frame decoder and the matching TX-side framer.
package frame_rx_pkg;
  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    TRL = 2'd2
  } state_t;

  localparam logic [7:0] FRAME_MAGIC = 8'hA5;
endpackage

// File: rtl/frame_rx_outreg.sv
// Single-entry output register with valid/ready handshake and a last flag.
module frame_rx_outreg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bits,
  input  logic             load_last,
  output logic             load_rdy,
  output logic             out_val,
  output logic [WIDTH-1:0] out_bits,
  output logic             out_last,
  input  logic             out_rdy
);
  // Slot is free when empty or draining this cycle.
  assign load_rdy = !out_val || out_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val  <= 1'b0;
      out_last <= 1'b0;
      out_bits <= '0;
    end else if (load) begin
      out_val  <= 1'b1;
      out_last <= load_last;
      out_bits <= load_bits;
    end else if (out_val && out_rdy) begin
      out_val  <= 1'b0;
      out_last <= 1'b0;
    end
  end
endmodule

// File: rtl/frame_rx.sv
// Frame decoder: strips header/trailer, forwards payload cut-through, checks magic and XOR sum.
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int         WIDTH     = 64,
  parameter int         LEN_WIDTH = 8,
  parameter logic [7:0] MAGIC     = FRAME_MAGIC,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_val,
  input  logic [WIDTH-1:0]     in_bits,
  output logic                 in_rdy,
  output logic                 out_val,
  output logic [WIDTH-1:0]     out_bits,
  output logic                 out_last,
  input  logic                 out_rdy,
  output logic                 done_val,
  output logic                 done_ok,
  output logic                 magic_err,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt
);
  state_t               state, state_n;
  logic [WIDTH-1:0]     sum;
  logic [LEN_WIDTH-1:0] rem;
  logic                 load_rdy, acc, hdr_ok, load, rem_last;

  // in_rdy depends only on state and the output slot, never on in_val.
  assign in_rdy   = (state == PAY) ? load_rdy : 1'b1;
  assign acc      = in_val && in_rdy;
  assign hdr_ok   = in_bits[WIDTH-1 -: 8] == MAGIC;
  assign load     = acc && (state == PAY);
  assign rem_last = rem == LEN_WIDTH'(1);

  frame_rx_outreg #(.WIDTH(WIDTH)) u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_bits (in_bits),
    .load_last (rem_last),
    .load_rdy  (load_rdy),
    .out_val   (out_val),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .out_rdy   (out_rdy)
  );

  always_comb begin
    state_n = state;
    case (state)
      HDR: if (acc && hdr_ok)
             state_n = (in_bits[LEN_WIDTH-1:0] != '0) ? PAY : TRL;
      PAY: if (acc && rem_last) state_n = TRL;
      TRL: if (acc) state_n = HDR;
      default: state_n = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= HDR;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum       <= '0;
      rem       <= '0;
      done_val  <= 1'b0;
      done_ok   <= 1'b0;
      magic_err <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      done_val  <= 1'b0;
      magic_err <= 1'b0;
      if (acc) begin
        case (state)
          HDR: begin
            if (hdr_ok) begin
              sum <= in_bits;
              rem <= in_bits[LEN_WIDTH-1:0];
            end else begin
              magic_err <= 1'b1;
            end
          end
          PAY: begin
            sum <= sum ^ in_bits;
            rem <= rem - LEN_WIDTH'(1);
          end
          TRL: begin
            done_val <= 1'b1;
            done_ok  <= in_bits == sum;
            // Counters saturate at all-ones.
            if (in_bits == sum) begin
              if (good_cnt != '1) good_cnt <= good_cnt + CNT_WIDTH'(1);
            end else begin
              if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_rx.sv
// Randomized bench for frame_rx: frames built from the format rules, outputs scored against queues.
module tb_frame_rx;
  localparam int         WIDTH     = 64;
  localparam int         LEN_WIDTH = 8;
  localparam int         CNT_WIDTH = 16;
  localparam logic [7:0] MAGIC     = 8'hA5;

  logic                 clk = 1'b0, reset_n = 1'b0;
  logic                 in_val = 1'b0, in_rdy;
  logic [WIDTH-1:0]     in_bits = '0, out_bits;
  logic                 out_val, out_last, out_rdy = 1'b0;
  logic                 done_val, done_ok, magic_err;
  logic [CNT_WIDTH-1:0] good_cnt, bad_cnt;

  frame_rx #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .MAGIC(MAGIC), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_bits(in_bits), .in_rdy(in_rdy),
    .out_val(out_val), .out_bits(out_bits), .out_last(out_last), .out_rdy(out_rdy),
    .done_val(done_val), .done_ok(done_ok), .magic_err(magic_err),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: 1,0,0 pattern, 3: never
  bit gaps = 0;
  logic [WIDTH:0] obs_out[$], exp_out[$];
  int obs_out_cyc[$];
  bit obs_done[$], exp_done[$];
  int obs_done_cyc[$];
  int obs_magic = 0, exp_magic = 0, exp_good = 0, exp_bad = 0;
  int rdy_viol = 0, stab_viol = 0, rdy_low = 0, last_acc_cyc = 0;
  bit prev_stall = 0;
  logic [WIDTH:0] prev_word = '0;

  // One clock cycle, starting and ending at a negedge. kind: 0 hdr/trl, 1 payload, 2 idle.
  task automatic step(input logic v, input logic [WIDTH-1:0] w, input int kind, output bit acc);
    logic r;
    case (rdy_mode)
      0: r = 1'b1;
      1: r = 1'($urandom_range(0, 1));
      2: r = (cyc % 3) == 0;
      default: r = 1'b0;
    endcase
    in_val = v; in_bits = w; out_rdy = r;
    #1;
    if (prev_stall && (!out_val || {out_last, out_bits} !== prev_word)) stab_viol++;
    prev_stall = out_val && !out_rdy;
    prev_word  = {out_last, out_bits};
    if (out_val && out_rdy) begin obs_out.push_back({out_last, out_bits}); obs_out_cyc.push_back(cyc); end
    if (done_val) begin obs_done.push_back(done_ok); obs_done_cyc.push_back(cyc); end
    if (magic_err) obs_magic++;
    if (kind == 1 && in_rdy !== (!out_val || out_rdy)) rdy_viol++;
    if (kind == 1 && in_rdy === 1'b0) rdy_low++;
    if (kind == 0 && in_rdy !== 1'b1) rdy_viol++;
    acc = v && in_rdy;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic [WIDTH-1:0] w, input int kind);
    bit a = 0;
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 1)) step(1'b0, '0, 2, a);
    a = 0;
    while (!a && n < 300) begin step(1'b1, w, kind, a); n++; end
    if (!a) begin
      checks++; errors++;
      $display("FAIL push_timeout: word %h not accepted after %0d cycles, want acceptance", w, n);
    end
    last_acc_cyc = cyc - 1;
  endtask

  task automatic drain();
    bit a;
    int saved = rdy_mode;
    rdy_mode = 0;
    repeat (4) step(1'b0, '0, 2, a);
    rdy_mode = saved;
    in_val = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [WIDTH-1:0] pay[$], input bit corrupt);
    logic [WIDTH-1:0] h, x;
    h = {$urandom, $urandom};
    h[WIDTH-1 -: 8] = MAGIC;
    h[LEN_WIDTH-1:0] = n[LEN_WIDTH-1:0];
    x = h;
    push(h, 0);
    for (int i = 0; i < n; i++) begin
      x ^= pay[i];
      exp_out.push_back({i == n - 1, pay[i]});
      push(pay[i], 1);
    end
    if (corrupt) x[0] = ~x[0];
    push(x, 0);
    exp_done.push_back(!corrupt);
    if (corrupt) exp_bad++; else exp_good++;
  endtask

  task automatic send_random(input int n, input bit corrupt);
    logic [WIDTH-1:0] q[$];
    for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
    send_frame(n, q, corrupt);
  endtask

  function automatic int out_diff();
    int d = int'(obs_out.size() != exp_out.size());
    for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++)
      if (obs_out[i] !== exp_out[i]) d++;
    return d;
  endfunction

  function automatic int done_diff();
    int d = int'(obs_done.size() != exp_done.size());
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      if (obs_done[i] !== exp_done[i]) d++;
    return d;
  endfunction

  task automatic clear_obs();
    obs_out.delete(); exp_out.delete(); obs_out_cyc.delete();
    obs_done.delete(); exp_done.delete(); obs_done_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (done_val !== 1'b0 || done_ok !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b want 0/0", done_val, done_ok); end
    checks++; if (magic_err !== 1'b0) begin errors++; $display("FAIL reset_magic_err: got %b want 0", magic_err); end
    checks++; if (good_cnt !== '0 || bad_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", good_cnt, bad_cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] q[$];
    int trl_cyc;
    clear_obs(); rdy_mode = 0; gaps = 0;
    q.push_back(64'd1); q.push_back(64'd2); q.push_back(64'd3);
    send_frame(3, q, 0);
    trl_cyc = last_acc_cyc;
    drain();
    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL basic_out: got %0d words with %0d diffs, want 3 words", obs_out.size(), out_diff()); end
    checks++;
    if (obs_out_cyc.size() != 3 || obs_out_cyc[1] != obs_out_cyc[0] + 1 || obs_out_cyc[2] != obs_out_cyc[0] + 2) begin
      errors++; $display("FAIL basic_consecutive: output words not on consecutive cycles (count %0d), want 3 consecutive", obs_out_cyc.size());
    end
    checks++; if (done_diff() !== 0) begin errors++; $display("FAIL basic_done: got %0d events %0d diffs, want 1 ok", obs_done.size(), done_diff()); end
    checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != trl_cyc + 1) begin
      errors++; $display("FAIL basic_done_latency: got %0d events, want one at cycle %0d", obs_done_cyc.size(), trl_cyc + 1);
    end
    checks++; if (good_cnt !== CNT_WIDTH'(exp_good)) begin errors++; $display("FAIL basic_good_cnt: got %0d want %0d", good_cnt, exp_good); end
  endtask

  task automatic test_bad_trailer();
    logic [WIDTH-1:0] q[$];
    clear_obs(); rdy_mode = 0;
    q.push_back(64'd1); q.push_back(64'd2); q.push_back(64'd3);
    send_frame(3, q, 1);
    drain();
    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL bad_out: got %0d words %0d diffs, want 3 intact", obs_out.size(), out_diff()); end
    checks++; if (done_diff() !== 0) begin errors++; $display("FAIL bad_done: got %0d events %0d diffs, want one with ok=0", obs_done.size(), done_diff()); end
    checks++; if (bad_cnt !== CNT_WIDTH'(exp_bad)) begin errors++; $display("FAIL bad_cnt: got %0d want %0d", bad_cnt, exp_bad); end
  endtask

  task automatic test_magic();
    logic [WIDTH-1:0] bad_hdr;
    clear_obs(); rdy_mode = 0;
    bad_hdr = {8'h00, 48'h0, 8'd1};
    push(bad_hdr, 0);
    exp_magic++;
    send_random(1, 0);
    drain();
    checks++; if (obs_magic !== exp_magic) begin errors++; $display("FAIL magic_pulses: got %0d want %0d", obs_magic, exp_magic); end
    checks++; if (out_diff() !== 0 || done_diff() !== 0) begin errors++; $display("FAIL magic_frame: out diffs %0d done diffs %0d, want 0/0", out_diff(), done_diff()); end
    checks++; if (good_cnt !== CNT_WIDTH'(exp_good)) begin errors++; $display("FAIL magic_good_cnt: got %0d want %0d", good_cnt, exp_good); end
  endtask

  task automatic test_zero_len();
    clear_obs(); rdy_mode = 0;
    send_random(0, 0);
    drain();
    checks++; if (obs_out.size() !== 0) begin errors++; $display("FAIL zero_out: got %0d words want 0", obs_out.size()); end
    checks++; if (done_diff() !== 0) begin errors++; $display("FAIL zero_done: got %0d events %0d diffs, want one ok", obs_done.size(), done_diff()); end
    checks++; if (good_cnt !== CNT_WIDTH'(exp_good)) begin errors++; $display("FAIL zero_good_cnt: got %0d want %0d", good_cnt, exp_good); end
  endtask

  task automatic test_backpressure();
    clear_obs(); rdy_mode = 2; rdy_low = 0; rdy_viol = 0; stab_viol = 0;
    send_random(4, 0);
    drain();
    checks++; if (rdy_low == 0) begin errors++; $display("FAIL bp_stalled: in_rdy low %0d times, want at least 1", rdy_low); end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL bp_in_rdy: got %0d violations want 0", rdy_viol); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_viol); end
    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL bp_out: got %0d words %0d diffs, want 4", obs_out.size(), out_diff()); end
    checks++; if (good_cnt !== CNT_WIDTH'(exp_good)) begin errors++; $display("FAIL bp_good_cnt: got %0d want %0d", good_cnt, exp_good); end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    int start;
    clear_obs(); rdy_mode = 0; gaps = 0;
    start = cyc;
    send_random(2, 0); send_random(5, 1); send_random(1, 0);
    checks++; if (cyc - start !== 14) begin errors++; $display("FAIL b2b_cycles: got %0d cycles want 14", cyc - start); end
    drain();
    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL b2b_out: got %0d words %0d diffs, want 8", obs_out.size(), out_diff()); end
    checks++; if (done_diff() !== 0) begin errors++; $display("FAIL b2b_done: got %0d events %0d diffs, want 3", obs_done.size(), done_diff()); end
    checks++; if (good_cnt !== CNT_WIDTH'(exp_good) || bad_cnt !== CNT_WIDTH'(exp_bad)) begin
      errors++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_random();
    clear_obs(); rdy_mode = 1; gaps = 1; rdy_viol = 0; stab_viol = 0;
    for (int f = 0; f < 12; f++) send_random(int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));
    send_random(255, 0);
    gaps = 0;
    drain();
    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL rand_out: got %0d words %0d diffs, want %0d", obs_out.size(), out_diff(), exp_out.size()); end
    checks++; if (done_diff() !== 0) begin errors++; $display("FAIL rand_done: got %0d events %0d diffs, want %0d", obs_done.size(), done_diff(), exp_done.size()); end
    checks++; if (good_cnt !== CNT_WIDTH'(exp_good) || bad_cnt !== CNT_WIDTH'(exp_bad)) begin
      errors++; $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
    checks++; if (rdy_viol !== 0 || stab_viol !== 0) begin errors++; $display("FAIL rand_handshake: rdy viol %0d stab viol %0d, want 0/0", rdy_viol, stab_viol); end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] h;
    bit a;
    clear_obs(); rdy_mode = 3;
    h = {MAGIC, 48'h0, 8'd3};
    push(h, 0);
    push(64'h11, 1);
    step(1'b1, 64'h22, 1, a);
    checks++; if (a !== 1'b0 || out_val !== 1'b1) begin errors++; $display("FAIL mid_stall: accepted %b out_val %b, want 0/1", a, out_val); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mid_async_out_val: got %b want 0", out_val); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL mid_in_rdy: got %b want 1", in_rdy); end
    @(negedge clk);
    reset_n = 1'b1;
    prev_stall = 0; exp_good = 0; exp_bad = 0;
    clear_obs(); rdy_mode = 0;
    send_random(2, 0);
    drain();
    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL mid_out: got %0d words %0d diffs, want 2", obs_out.size(), out_diff()); end
    checks++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d/%0d want 1/0", good_cnt, bad_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_trailer();
    test_magic();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
